l2_credit_arbiter: RTL
======================

# l2_credit_arbiter

Credit-aware weighted round-robin arbiter for the L2 request path. It chooses which requester's head-of-queue request moves into the memory address FIFO. A read is granted only when the requester's read-return FIFO has space for the whole response. This removes the risk of return-data overflow when a requester is slow to acknowledge read data.

## Interface
Parameters:
- NUM_PORTS, default L2_NUM_PORTS: number of requesters.
- RETURN_DEPTH, default L2_READ_RETURN_FIFO_DEPTHS: per-port read-return FIFO depth, in words; this is the initial credit count.
- WEIGHT, default 1: maximum consecutive grants to one port before the priority pointer moves on (1..16).
- CW, default $clog2(RETURN_DEPTH+1): credit counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- requests  in  NUM_PORTS  head-of-queue valid, per port.
- req_rnw  in  NUM_PORTS  head request is a read (1) or a write (0).
- req_burst  in  NUM_PORTS×5  head request burst size minus 1, in words.
- strobe  in  1  downstream accepted the current grant this cycle.
- credit_release  in  NUM_PORTS  requester popped one read-return word (rd_data_ack).
- grantee_valid  out  1  some port is granted.
- grantee_v  out  NUM_PORTS  one-hot grant.
- grantee_i  out  $clog2(NUM_PORTS)  binary grant index.
- credits  out  NUM_PORTS×CW  current credits per port, for debug and assertions.

## Operation
- need[p] = min(req_burst[p]+1, RETURN_DEPTH) if req_rnw[p], else 0.
- eligible[p] = requests[p] & (credits[p] >= need[p]).
- Grant selection is combinational:
  - Search the eligible ports starting at pointer ptr, wrapping around.
  - The first eligible port found wins.
  - If no port is eligible: grantee_valid=0, grantee_v=0, grantee_i=0.
- Quantum rule:
  - Keep a counter q and the index of the last granted port, last.
  - On strobe with grantee_i==last: q increments.
  - When q reaches WEIGHT-1 on a strobe, ptr←grantee_i+1 (mod NUM_PORTS) and q←0.
  - On strobe to a different port: last←grantee_i, q←0; ptr advances past that port only if WEIGHT==1.
  - With no strobe, ptr and q hold.
- Credits, per cycle and per port:
  - credits_next = credits − (strobe & grantee_v[p] ? need[p] : 0) + credit_release[p].
  - A grant and a release in the same cycle apply together.
  - A release at credits==RETURN_DEPTH saturates the counter; this is an assertion violation.
- Writes never consume credits.
- An ineligible read does not block other ports. It waits until enough releases arrive; no deadlock is possible, because in-flight words are eventually acknowledged.
- Requests with burst+1 > RETURN_DEPTH need full credits; they are clamped and flagged by an assertion.

## Timing
- Reset values:
  - credits = RETURN_DEPTH for every port.
  - ptr=0, q=0, last=0.
  - Grant outputs follow requests combinationally; they are 0 while requests=0.
- Grant latency: 0 cycles from requests/credits to grantee_*. State updates on the clock edge at which strobe=1.
- The grant must stay stable while strobe=0 and inputs are unchanged. Upstream holds requests until strobe.
- strobe with grantee_valid=0 is illegal and is ignored.
- A release in cycle N is visible in credits and eligibility in cycle N+1.
- Reset mid-operation restores full credits. Requesters must flush their return FIFOs under the same reset.

## Structure
- In l2_config_and_types:
  - L2_NUM_PORTS, L2_READ_RETURN_FIFO_DEPTHS, L2_ARB_WEIGHT.
  - An l2_credit_t typedef.
- Sub-module l2_credit_counter, one per port:
  - Inputs: consume amount, release pulse.
  - Outputs: count, overflow flag.
- The top level holds the wrap-around priority search and the ptr/q state.
- Drop-in behind an l2_arbitration_interface-style connection, replacing the plain round-robin.

## Test plan
1. Reset with RETURN_DEPTH=8, NUM_PORTS=2, WEIGHT=1 → credits={8,8}, grantee_valid=0.
2. Both ports request 1-word reads continuously with strobe every cycle → grants alternate 0,1,0,1. After 4 grants with no releases, credits={6,6}.
3. Port0 read burst=7 (need 8) with credits 7; port1 write → port1 granted. One release on port0 → port0 is granted next cycle, and credits[0] becomes 0.
4. Grant of a need-4 read to port1 in the same cycle as credit_release[1] with credits 5 → credits[1]=2.
5. WEIGHT=3, both ports always eligible → grant sequence 0,0,0,1,1,1,0.
6. Reset asserted mid-burst with credits={2,5} → next cycle credits={8,8}, ptr=0, grant goes to port0.

Source files
------------

// File: rtl/l2_credit_arbiter_pkg.sv
// Shared L2 configuration constants and the read-credit sizing helper.
package l2_config_and_types;

    localparam int unsigned L2_NUM_PORTS               = 4;
    localparam int unsigned L2_READ_RETURN_FIFO_DEPTHS = 8;
    localparam int unsigned L2_ARB_WEIGHT              = 1;
    localparam int unsigned L2_BURST_W                 = 5;
    localparam int unsigned L2_CREDIT_W                = $clog2(L2_READ_RETURN_FIFO_DEPTHS + 1);

    typedef logic [L2_CREDIT_W-1:0] l2_credit_t;

    // Return-FIFO words a head request will occupy; oversize bursts clamp to a full FIFO.
    function automatic int unsigned l2_read_need(input logic rnw,
                                                 input logic [L2_BURST_W-1:0] burst,
                                                 input int unsigned depth);
        int unsigned words;
        words = 32'(burst) + 1;
        if (!rnw)
            return 0;
        return (words > depth) ? depth : words;
    endfunction

endpackage

// File: rtl/l2_credit_arbiter_counter.sv
// Per-port read-return credit counter: subtracts granted words, adds acknowledged ones.
module l2_credit_counter #(
    parameter int unsigned RETURN_DEPTH = 8,
    parameter int unsigned CW           = $clog2(RETURN_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] i_consume,
    input  logic          i_release,
    output logic [CW-1:0] o_count,
    output logic          o_overflow
);

    localparam logic [CW:0]   DEPTH_W = (CW+1)'(RETURN_DEPTH);
    localparam logic [CW-1:0] DEPTH_N = CW'(RETURN_DEPTH);

    logic [CW-1:0] r_count;
    logic [CW:0]   w_sum;

    // Consume never exceeds the count (eligibility), so one extra bit covers the release carry.
    always_comb begin
        w_sum      = {1'b0, r_count} + (CW+1)'(i_release) - {1'b0, i_consume};
        o_overflow = (w_sum > DEPTH_W);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= DEPTH_N;
        else if (o_overflow)
            r_count <= DEPTH_N;
        else
            r_count <= w_sum[CW-1:0];
    end

    assign o_count = r_count;

endmodule

// File: rtl/l2_credit_arbiter.sv
// Credit-aware weighted round-robin arbiter feeding the L2 memory address FIFO.
module l2_credit_arbiter
    import l2_config_and_types::*;
#(
    parameter int unsigned NUM_PORTS    = L2_NUM_PORTS,
    parameter int unsigned RETURN_DEPTH = L2_READ_RETURN_FIFO_DEPTHS,
    parameter int unsigned WEIGHT       = L2_ARB_WEIGHT,
    parameter int unsigned CW           = $clog2(RETURN_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         requests,
    input  logic [NUM_PORTS-1:0]         req_rnw,
    input  logic [NUM_PORTS*5-1:0]       req_burst,
    input  logic                         strobe,
    input  logic [NUM_PORTS-1:0]         credit_release,
    output logic                         grantee_valid,
    output logic [NUM_PORTS-1:0]         grantee_v,
    output logic [$clog2(NUM_PORTS)-1:0] grantee_i,
    output logic [NUM_PORTS*CW-1:0]      credits
);

    localparam int unsigned   IW       = $clog2(NUM_PORTS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PORTS - 1);

    logic [CW-1:0]        w_credit  [NUM_PORTS];
    logic [CW-1:0]        w_need    [NUM_PORTS];
    logic [CW-1:0]        w_consume [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_eligible;
    logic [NUM_PORTS-1:0] w_clamped;
    logic [NUM_PORTS-1:0] w_overflow;
    logic [IW-1:0]        w_idx;
    logic                 w_fire;
    logic [4:0]           w_run_next;

    logic [IW-1:0]        r_ptr;
    logic [IW-1:0]        r_last;
    logic [4:0]           r_run;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            w_need[p]     = CW'(l2_read_need(req_rnw[p], req_burst[p*5 +: 5], RETURN_DEPTH));
            w_clamped[p]  = requests[p] & req_rnw[p] & ((32'(req_burst[p*5 +: 5]) + 1) > RETURN_DEPTH);
            w_eligible[p] = requests[p] & (w_credit[p] >= w_need[p]);
        end
    end

    always_comb begin
        grantee_valid = 1'b0;
        grantee_i     = '0;
        w_idx         = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_idx = IW'((32'(r_ptr) + k) % NUM_PORTS);
            if (!grantee_valid && w_eligible[w_idx]) begin
                grantee_valid = 1'b1;
                grantee_i     = w_idx;
            end
        end
    end

    always_comb begin
        grantee_v = '0;
        if (grantee_valid)
            grantee_v[grantee_i] = 1'b1;
    end

    assign w_fire = strobe & grantee_valid;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++)
            w_consume[p] = (w_fire && grantee_v[p]) ? w_need[p] : '0;
    end

    // r_run counts grants in the current run (0 = none yet), so the first grant
    // after reset or after a rotation counts toward the quantum like any other.
    assign w_run_next = (grantee_i == r_last) ? r_run + 5'd1 : 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_last <= '0;
            r_run  <= '0;
        end else if (w_fire) begin
            r_last <= grantee_i;
            if (32'(w_run_next) >= WEIGHT) begin
                r_ptr <= (grantee_i == LAST_IDX) ? '0 : grantee_i + IW'(1);
                r_run <= '0;
            end else begin
                r_run <= w_run_next;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        l2_credit_counter #(
            .RETURN_DEPTH(RETURN_DEPTH),
            .CW          (CW)
        ) u_credit (
            .clk       (clk),
            .rst       (rst),
            .i_consume (w_consume[p]),
            .i_release (credit_release[p]),
            .o_count   (w_credit[p]),
            .o_overflow(w_overflow[p])
        );
        assign credits[p*CW +: CW] = w_credit[p];
    end

    a_no_credit_overflow: assert property (@(posedge clk) disable iff (rst) w_overflow == '0);
    a_no_oversize_read:   assert property (@(posedge clk) disable iff (rst) w_clamped == '0);

endmodule
